// File: rtl/pc_gen_if.sv
// Bus bundle for pc_gen: control and redirect inputs, and the PC, status and counter outputs.
interface pc_gen_if #(
    parameter int PC_WIDTH  = 12,
    parameter int CNT_WIDTH = 16
);
    logic [2:0]           pc_src;
    logic [PC_WIDTH-1:0]  target_branch;
    logic [PC_WIDTH-1:0]  target_jal;
    logic [PC_WIDTH-1:0]  target_jalr;
    logic                 stall;
    logic                 halt_req;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  next_pc;
    logic                 pc_valid;
    logic                 halted;
    logic                 err_illegal_src;
    logic                 err_misalign;
    logic [CNT_WIDTH-1:0] retire_cnt;

    modport master (
        output pc_src, target_branch, target_jal, target_jalr, stall, halt_req,
        input  pc, next_pc, pc_valid, halted, err_illegal_src, err_misalign, retire_cnt
    );

    modport slave (
        input  pc_src, target_branch, target_jal, target_jalr, stall, halt_req,
        output pc, next_pc, pc_valid, halted, err_illegal_src, err_misalign, retire_cnt
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with stall, one-entry pending redirect, halt and retire counter.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect traps to HALT instead of being masked.
//
// state   | meaning
// S_RUN   | PC advances every cycle on a legal select
// S_STALL | PC held; latest redirect kept in the pending register
// S_HALT  | everything frozen until rst
module pc_gen #(
    parameter int                     PC_WIDTH  = 12,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter int                     CNT_WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_HALT = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [PC_WIDTH-1:0]  pc_q, pc_nxt;
    logic [PC_WIDTH-1:0]  pend_tgt, pend_tgt_nxt;
    logic                 pend_vld, pend_vld_nxt;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
    logic                 err_ill_q, err_ill_nxt;
    logic [PC_WIDTH-1:0]  inc4, src_tgt, load_tgt;
    logic                 src_legal, src_redirect, do_load;
`ifdef PC_MISALIGN_TRAP_EN
    logic                 err_mis_q, err_mis_nxt;
`endif

    assign inc4 = pc_q + PC_WIDTH'(4);

    always_comb begin
        src_legal    = 1'b1;
        src_redirect = 1'b1;
        src_tgt      = inc4;
        case (bus.pc_src)
            3'b000: src_redirect = 1'b0;
            3'b001: src_tgt = bus.target_branch;
            3'b110: src_tgt = bus.target_jal;
            3'b100: src_tgt = bus.target_jalr;
            default: begin
                src_legal    = 1'b0;
                src_redirect = 1'b0;
                src_tgt      = pc_q;
            end
        endcase
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        cnt_nxt      = cnt_q;
        err_ill_nxt  = err_ill_q;
        do_load      = 1'b0;
        load_tgt     = src_tgt;
`ifdef PC_MISALIGN_TRAP_EN
        err_mis_nxt  = err_mis_q;
`endif
        case (state)
            S_RUN: begin
                if (bus.halt_req) begin
                    state_nxt    = S_HALT;
                    pend_vld_nxt = 1'b0;
                end else if (bus.stall) begin
                    state_nxt = S_STALL;
                    if (src_legal && src_redirect) begin
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = src_tgt;
                    end
                end else if (!src_legal) begin
                    err_ill_nxt = 1'b1;
                end else begin
                    do_load = 1'b1;
                end
            end
            S_STALL: begin
                if (bus.halt_req) begin
                    state_nxt    = S_HALT;
                    pend_vld_nxt = 1'b0;
                end else if (bus.stall) begin
                    if (src_legal && src_redirect) begin
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = src_tgt;
                    end
                end else begin
                    state_nxt    = S_RUN;
                    pend_vld_nxt = 1'b0;
                    if (pend_vld) begin
                        do_load  = 1'b1;
                        load_tgt = pend_tgt;
                    end else if (!src_legal) begin
                        err_ill_nxt = 1'b1;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // pc is always word aligned, so only a redirect target can carry low bits
        if (do_load) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (load_tgt[1:0] != 2'b00) begin
                err_mis_nxt  = 1'b1;
                state_nxt    = S_HALT;
                pend_vld_nxt = 1'b0;
            end else begin
                pc_nxt  = load_tgt;
                cnt_nxt = cnt_q + CNT_WIDTH'(1);
            end
`else
            pc_nxt  = load_tgt & ~PC_WIDTH'(3);
            cnt_nxt = cnt_q + CNT_WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            pc_q      <= RESET_PC;
            pend_vld  <= 1'b0;
            pend_tgt  <= '0;
            cnt_q     <= '0;
            err_ill_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            err_mis_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pc_q      <= pc_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_tgt  <= pend_tgt_nxt;
            cnt_q     <= cnt_nxt;
            err_ill_q <= err_ill_nxt;
`ifdef PC_MISALIGN_TRAP_EN
            err_mis_q <= err_mis_nxt;
`endif
        end
    end

    assign bus.pc              = pc_q;
    assign bus.next_pc         = pc_nxt;
    assign bus.pc_valid        = (state != S_HALT);
    assign bus.halted          = (state == S_HALT);
    assign bus.err_illegal_src = err_ill_q;
    assign bus.retire_cnt      = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.err_misalign    = err_mis_q;
`else
    assign bus.err_misalign    = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver pushes hand-computed expectations, monitor pops and compares.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.PC_WIDTH(12), .CNT_WIDTH(4)) bus ();

    pc_gen #(.PC_WIDTH(12), .RESET_PC(12'hFF8), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        chk_np;
        logic [11:0] np;
        logic [11:0] pc;
        logic        halted;
        logic        ill;
        logic        mis;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic [2:0] src,
                        input logic [11:0] tbr, input logic [11:0] tjl, input logic [11:0] tjr,
                        input logic st, input logic hl, input logic chk,
                        input logic [11:0] enp, input logic [11:0] epc,
                        input logic eh, input logic ei, input logic em, input logic [3:0] ec);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.pc_src        = src;
        bus.target_branch = tbr;
        bus.target_jal    = tjl;
        bus.target_jalr   = tjr;
        bus.stall         = st;
        bus.halt_req      = hl;
        e.name = nm; e.chk_np = chk; e.np = enp; e.pc = epc;
        e.halted = eh; e.ill = ei; e.mis = em; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    // monitor: next_pc sampled just before the edge, registered outputs just after
    initial begin : monitor
        logic [11:0] np_smp;
        exp_t e;
        forever begin
            @(negedge clk);
            #4 np_smp = bus.next_pc;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_np) cmp(e.name, "next_pc", 32'(np_smp), 32'(e.np));
                cmp(e.name, "pc",       32'(bus.pc),              32'(e.pc));
                cmp(e.name, "halted",   32'(bus.halted),          32'(e.halted));
                cmp(e.name, "pc_valid", 32'(bus.pc_valid),        32'(!e.halted));
                cmp(e.name, "err_ill",  32'(bus.err_illegal_src), 32'(e.ill));
                cmp(e.name, "err_mis",  32'(bus.err_misalign),    32'(e.mis));
                cmp(e.name, "cnt",      32'(bus.retire_cnt),      32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [11:0] p;
        bus.pc_src = 3'b000; bus.target_branch = '0; bus.target_jal = '0; bus.target_jalr = '0;
        bus.stall = 1'b0; bus.halt_req = 1'b0; rst = 1'b1;

        //    name        rst src     tbr     tjl     tjr     st hl chk np      pc      h  ill mis cnt
        step("reset0",    1, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
        step("reset1",    1, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
        step("wrap1",     0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'hFFC, 12'hFFC, 0, 0, 0, 4'd1);
        step("wrap2",     0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h000, 12'h000, 0, 0, 0, 4'd2);
        step("wrap3",     0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h004, 12'h004, 0, 0, 0, 4'd3);
        step("br100",     0, 3'b001, 12'h100, 12'h0, 12'h0,  0, 0, 1, 12'h100, 12'h100, 0, 0, 0, 4'd4);
        step("pend_st",   0, 3'b110, 12'h0,  12'h040, 12'h0, 1, 0, 1, 12'h100, 12'h100, 0, 0, 0, 4'd4);
        step("pend_hold", 0, 3'b000, 12'h0,  12'h0,  12'h0,  1, 0, 1, 12'h100, 12'h100, 0, 0, 0, 4'd4);
        step("pend_rel",  0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h040, 12'h040, 0, 0, 0, 4'd5);
        step("inc_044",   0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h044, 12'h044, 0, 0, 0, 4'd6);
        step("ovw_br",    0, 3'b001, 12'h200, 12'h0, 12'h0,  1, 0, 1, 12'h044, 12'h044, 0, 0, 0, 4'd6);
        step("ovw_jalr",  0, 3'b100, 12'h0,  12'h0,  12'h300, 1, 0, 1, 12'h044, 12'h044, 0, 0, 0, 4'd6);
        step("ovw_keep",  0, 3'b000, 12'h0,  12'h0,  12'h0,  1, 0, 1, 12'h044, 12'h044, 0, 0, 0, 4'd6);
        step("ovw_rel",   0, 3'b001, 12'h500, 12'h0, 12'h0,  0, 0, 1, 12'h300, 12'h300, 0, 0, 0, 4'd7);
        step("st_nopend", 0, 3'b000, 12'h0,  12'h0,  12'h0,  1, 0, 1, 12'h300, 12'h300, 0, 0, 0, 4'd7);
        step("rel_inc",   0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h304, 12'h304, 0, 0, 0, 4'd8);
        step("br010",     0, 3'b001, 12'h010, 12'h0, 12'h0,  0, 0, 1, 12'h010, 12'h010, 0, 0, 0, 4'd9);
        step("ill011",    0, 3'b011, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h010, 12'h010, 0, 1, 0, 4'd9);
        step("ill111",    0, 3'b111, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h010, 12'h010, 0, 1, 0, 4'd9);
        step("ill_stick", 0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h014, 12'h014, 0, 1, 0, 4'd10);
        step("jal0c0",    0, 3'b110, 12'h0,  12'h0C0, 12'h0, 0, 0, 1, 12'h0C0, 12'h0C0, 0, 1, 0, 4'd11);
        step("halt_in",   0, 3'b001, 12'h800, 12'h0, 12'h0,  1, 1, 1, 12'h0C0, 12'h0C0, 1, 1, 0, 4'd11);
        step("halt_frz",  0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h0C0, 12'h0C0, 1, 1, 0, 4'd11);
        step("halt_jal",  0, 3'b110, 12'h0,  12'h040, 12'h0, 0, 0, 1, 12'h0C0, 12'h0C0, 1, 1, 0, 4'd11);
        step("halt_rst",  1, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
`ifdef PC_MISALIGN_TRAP_EN
        step("mis_trap",  0, 3'b100, 12'h0,  12'h0,  12'h102, 0, 0, 1, 12'hFF8, 12'hFF8, 1, 0, 1, 4'd0);
        step("mis_frz",   0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'hFF8, 12'hFF8, 1, 0, 1, 4'd0);
`else
        step("mis_mask",  0, 3'b100, 12'h0,  12'h0,  12'h102, 0, 0, 1, 12'h100, 12'h100, 0, 0, 0, 4'd1);
        step("mis_inc",   0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'h104, 12'h104, 0, 0, 0, 4'd2);
`endif
        step("mis_rst",   1, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
        step("r_inc",     0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'hFFC, 12'hFFC, 0, 0, 0, 4'd1);
        step("r_pend",    0, 3'b110, 12'h0,  12'h040, 12'h0, 1, 0, 1, 12'hFFC, 12'hFFC, 0, 0, 0, 4'd1);
        step("r_rst",     1, 3'b110, 12'h0,  12'h040, 12'h0, 1, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
        step("r_clear",   0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 1, 12'hFFC, 12'hFFC, 0, 0, 0, 4'd1);
        step("h_run",     0, 3'b000, 12'h0,  12'h0,  12'h0,  0, 1, 1, 12'hFFC, 12'hFFC, 1, 0, 0, 4'd1);
        step("h_rst",     1, 3'b000, 12'h0,  12'h0,  12'h0,  0, 0, 0, 12'h0,  12'hFF8, 0, 0, 0, 4'd0);
        // retire counter is 4 bits here, so 16 advances bring it back to 0
        p = 12'hFF8;
        for (int k = 1; k <= 17; k++) begin
            p = p + 12'h004;
            step("cnt_wrap", 0, 3'b000, 12'h0, 12'h0, 12'h0, 0, 0, 1, p, p, 0, 0, 0, 4'(k));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter PC_WIDTH, default 12: width of PC, targets and next_pc; legal range 4..32.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-003 Parameter CNT_WIDTH, default 16: width of the retired-PC counter.
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 pc_src  in  3  next-PC select: 000 inc4, 001 branch, 110 JAL, 100 JALR; other codes illegal.
REQ-007 target_branch / target_jal / target_jalr  in  PC_WIDTH each  redirect targets.
REQ-008 stall  in  1  hold PC this cycle.
REQ-009 halt_req  in  1  enter HALT.
REQ-010 pc  out  PC_WIDTH  registered current PC.
REQ-011 next_pc  out  PC_WIDTH  combinational value PC will take at the next edge.
REQ-012 pc_valid  out  1  high when not in HALT.
REQ-013 halted  out  1  high in HALT.
REQ-014 err_illegal_src  out  1  sticky illegal-select flag.
REQ-015 err_misalign  out  1  sticky misaligned-target flag.
REQ-016 retire_cnt  out  CNT_WIDTH  count of PC advances.

Function
REQ-017 States RUN, STALL, HALT; RUN after reset.
REQ-018 inc4 = pc + 4, modulo 2^PC_WIDTH; 0xFFC (PC_WIDTH=12) SHALL wrap to 0x000.
REQ-019 RUN, stall=0, legal pc_src: pc <= selected target (or inc4) at the next edge; latency one cycle; retire_cnt += 1.
REQ-020 RUN, stall=1: pc holds; state -> STALL; a redirect (pc_src != 000, legal) SHALL be captured in a one-entry pending register.
REQ-021 STALL, stall=1: pc holds; a new redirect SHALL overwrite the pending entry; pc_src=000 SHALL leave it unchanged.
REQ-022 STALL, stall=0: the pending target, if valid, SHALL take priority over the current pc_src; pending is cleared; state -> RUN; retire_cnt += 1.
REQ-023 Illegal pc_src in RUN with stall=0: pc holds; err_illegal_src set; retire_cnt unchanged; state stays RUN.
REQ-024 halt_req=1 in any state SHALL move to HALT at the next edge, with priority over stall and redirects; pc holds; pending cleared.
REQ-025 HALT is sticky until RST; pc, retire_cnt and flags SHALL freeze; all inputs ignored.
REQ-026 next_pc SHALL equal pc whenever no update will occur (stall, HALT, illegal code, misalign trap).
REQ-027 retire_cnt SHALL wrap from all-ones to 0.

Reset
REQ-028 RST=1 at an edge SHALL set pc=RESET_PC, state=RUN, pending invalid, retire_cnt=0, err_illegal_src=0, err_misalign=0.
REQ-029 RST=1 at an edge SHALL also set halted=0; pc_valid=1 from the first cycle after reset.
REQ-030 RST SHALL override every other input, including mid-stall with a pending redirect and in HALT.

Configuration
REQ-031 Macro PC_MISALIGN_TRAP_EN defined: a selected redirect target with bits [1:0] != 0 SHALL set err_misalign and move to HALT; pc holds; retire_cnt unchanged.
REQ-032 Macro PC_MISALIGN_TRAP_EN undefined: target bits [1:0] SHALL be forced to 0 before loading; err_misalign SHALL be tied 0.

Verification
REQ-033 Scenario, wrap: reset; RESET_PC=0xFF8, PC_WIDTH=12; pc_src=000 for 3 cycles -> pc 0xFFC, 0x000, 0x004; retire_cnt=3.
REQ-034 Scenario, pending redirect: pc=0x100; stall=1 with pc_src=110, target_jal=0x040; next cycle pc_src=000; stall=0 -> pc=0x040 one cycle after release.
REQ-035 Scenario, overwrite: during a stall, redirect branch 0x200 then JALR 0x300 -> pc=0x300 after release.
REQ-036 Scenario, illegal code: pc_src=011 at pc=0x010 -> pc stays 0x010; err_illegal_src=1 until reset.
REQ-037 Scenario, halt: halt_req with stall=1 and pc_src=001 -> halted=1, pc_valid=0, pc frozen; RST -> pc=RESET_PC, halted=0.
REQ-038 Scenario, misalign: target_jalr=0x102 -> with macro: err_misalign=1, halted=1, pc unchanged; without macro: pc=0x100.
